lat_ctrl_seq: RTL and testbench
===============================

Name: lat_ctrl_seq

Overview:
- Clocked sequencer that sits directly upstream of a bank of W set/clear level-sensitive latches.
- Turns a valid/ready request stream (write, set, clear, nop) into glitch-free, non-overlapping en/pre/clr/d drive with guaranteed setup and hold phases.
- Reads the latch outputs back after each operation and flags mismatches.
- Also performs an automatic clear of the latch bank after reset.

Parameters:
- W, 4, width of data and latch bank.
- PULSE_CYC, 2, cycles lat_pre/lat_clr are held high for set/clear (minimum 1).
- HOLD_CYC, 1, cycles lat_d is held stable after lat_en falls (minimum 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_op  input  2  00 write, 01 set, 10 clear, 11 nop.
- req_data  input  W  write data; ignored for other ops.
- lat_d  output  W  latch data input.
- lat_en  output  1  latch transparent enable, active-high.
- lat_pre  output  1  latch preset, active-high.
- lat_clr  output  1  latch clear, active-high.
- lat_q  input  W  latch outputs, read back.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  one-cycle pulse coincident with done when the readback mismatches.
- err_cnt  output  8  saturating mismatch count.

Behaviour:
- All outputs are registered.
- Async reset values: req_ready=0, lat_d=0, lat_en=0, lat_pre=0, lat_clr=1, done=0, err=0, err_cnt=0, state=INIT, internal counter=0.
- States: INIT, IDLE, SETUP, OPEN, HOLD, PULSE, CHECK.
- INIT: lat_clr=1 for PULSE_CYC cycles after reset release, then CHECK with expected value all-zeros. req_ready stays 0 throughout.
- IDLE: req_ready=1, all latch controls 0, lat_d holds its last value.
- Accept happens on req_valid && req_ready at edge T. The op and data are captured, and req_ready drops at T.
- Write:
  - SETUP (cycle T+1): lat_d=req_data, lat_en=0.
  - OPEN (T+2): lat_en=1.
  - HOLD (T+3 .. T+2+HOLD_CYC): lat_en=0, lat_d unchanged.
  - CHECK: expected value = req_data.
- Set: PULSE for PULSE_CYC cycles with lat_pre=1, then CHECK with expected value all-ones.
- Clear: PULSE for PULSE_CYC cycles with lat_clr=1, then CHECK with expected value all-zeros.
- Nop: CHECK at T+1 with compare disabled; err is always 0.
- CHECK (1 cycle): done=1; err=1 iff compare is enabled and lat_q != expected. err_cnt increments on err and saturates at 255. Next state is IDLE, with req_ready=1 the following cycle.
- Latency, request accept to done: write = 3+HOLD_CYC cycles (4 at defaults); set/clear = PULSE_CYC+1 cycles (3 at defaults); nop = 1 cycle.
- Exclusivity invariant: at most one of lat_en, lat_pre, lat_clr is high in any cycle.
- lat_d never changes in a cycle where lat_en=1, nor in the cycle before or after it.
- Back-to-back requests: at most one accept per IDLE visit. A request held valid during busy states is not accepted until IDLE.
- Unknown ops are impossible (2-bit, all encoded).
- Reset asserted mid-operation: outputs go to reset values immediately, including lat_clr=1, which clears the bank. Any op in progress is abandoned without a done pulse. err_cnt clears.
- A readback mismatch does not stall or retry the sequencer. It only pulses err and counts.

Test Plan:
- Reset release with PULSE_CYC=2, lat_q tied to a model latch -> lat_clr high for 2 cycles, then done=1, err=0, and req_ready=1 on the next cycle.
- Write req_data=4'hA accepted at T -> lat_d=A at T+1; lat_en high only at T+2; lat_d stable through T+3; done at T+4 with err=0 and model q=A.
- Set, then clear, back-to-back with req_valid held -> lat_pre high 2 cycles, done, one IDLE cycle, lat_clr high 2 cycles, done. lat_pre and lat_clr are never high together; final q=0.
- Write 4'h5 with lat_q forced to 4'h4 -> done and err pulse together at T+4; err_cnt=1. Repeat 300 times -> err_cnt=255.
- Nop -> done at T+1; no latch control asserted; err=0 even with lat_q forced to mismatch.
- rst_n asserted during the OPEN cycle of a write -> lat_en=0 and lat_clr=1 immediately; no done pulse; after release, the INIT clear sequence repeats.

Source files
------------

// File: rtl/lat_ctrl_seq.sv
// lat_ctrl_seq: drives a bank of set/clear level-sensitive latches from a
// valid/ready request stream and checks the latch outputs after each operation.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | post-reset clear of the bank, lat_clr high for PULSE_CYC
// IDLE  | req_ready high, latch controls low, lat_d parked
// SETUP | new write data on lat_d, enable still low (setup phase)
// OPEN  | lat_en high, latches transparent
// HOLD  | lat_en low, lat_d held for HOLD_CYC cycles (hold phase)
// PULSE | lat_pre or lat_clr held high for PULSE_CYC cycles
// CHECK | done pulse, readback result reported on err
module lat_ctrl_seq #(
  parameter int W         = 4,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  output logic [W-1:0] lat_d,
  output logic         lat_en,
  output logic         lat_pre,
  output logic         lat_clr,
  input  logic [W-1:0] lat_q,
  output logic         done,
  output logic         err,
  output logic [7:0]   err_cnt
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_PULSE = 3'd5;
  localparam logic [2:0] S_CHECK = 3'd6;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam int CMAX = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [W-1:0]  lat_d_q, lat_d_d;
  logic          en_q, en_d;
  logic          pre_q, pre_d;
  logic          clr_q, clr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  // Next-state and next-output decode; every output is registered so the
  // latch controls can never glitch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    lat_d_d   = lat_d_q;
    en_d      = en_q;
    pre_d     = pre_q;
    clr_d     = clr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
          clr_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = (lat_q != '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          case (req_op)
            OP_WRITE: begin
              lat_d_d = req_data;
              state_d = S_SETUP;
            end
            OP_SET: begin
              pre_d   = 1'b1;
              state_d = S_PULSE;
            end
            OP_CLEAR: begin
              clr_d   = 1'b1;
              state_d = S_PULSE;
            end
            default: begin
              done_d  = 1'b1;
              state_d = S_CHECK;
            end
          endcase
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        state_d = S_OPEN;
      end
      S_OPEN: begin
        en_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_CHECK;
          done_d  = 1'b1;
          err_d   = (lat_q != lat_d_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_CHECK;
          pre_d   = 1'b0;
          clr_d   = 1'b0;
          done_d  = 1'b1;
          // the active pulse tells us which value the bank should now hold
          err_d   = pre_q ? (lat_q != '1) : (lat_q != '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        pre_d   = 1'b0;
        clr_d   = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // State and output registers; reset parks the bank in clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      lat_d_q   <= '0;
      en_q      <= 1'b0;
      pre_q     <= 1'b0;
      clr_q     <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      lat_d_q   <= lat_d_d;
      en_q      <= en_d;
      pre_q     <= pre_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign req_ready = ready_q;
  assign lat_d     = lat_d_q;
  assign lat_en    = en_q;
  assign lat_pre   = pre_q;
  assign lat_clr   = clr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lat_ctrl_seq.sv
// Bench for lat_ctrl_seq: a behavioural latch bank on lat_q, per-operation
// expected timelines derived from op latency, and free-running invariant checks.
module tb_lat_ctrl_seq;
  localparam int W = 4;
  localparam int P = 2;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [1:0]   req_op = 2'd3;
  logic [W-1:0] req_data = '0;
  logic         req_ready;
  logic [W-1:0] lat_d;
  logic         lat_en, lat_pre, lat_clr, done, err;
  logic [7:0]   err_cnt;
  logic [W-1:0] lq;
  logic [W-1:0] lat_q;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  int n_vec = 0;
  int n_err = 0;
  int cnt_model = 0;
  logic [W-1:0] bank_m = '0;
  logic [W-1:0] last_d = '0;

  lat_ctrl_seq #(.W(W), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .lat_d(lat_d), .lat_en(lat_en),
    .lat_pre(lat_pre), .lat_clr(lat_clr), .lat_q(lat_q), .done(done),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // behavioural set/clear latch bank, clear dominant
  always @(negedge clk) begin
    if (lat_clr) lq <= '0;
    else if (lat_pre) lq <= '1;
    else if (lat_en) lq <= lat_d;
  end
  assign lat_q = force_en ? force_val : lq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // invariants: one control at a time, lat_d frozen around an enable
  logic         prev_ok = 1'b0;
  logic         prev_en = 1'b0;
  logic [W-1:0] prev_d = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot", 32'(lat_en + lat_pre + lat_clr <= 1), 32'(1));
      if (prev_ok && (lat_en || prev_en)) chk("d_stable", 32'(lat_d), 32'(prev_d));
      prev_ok <= 1'b1;
    end else begin
      prev_ok <= 1'b0;
    end
    prev_en <= lat_en;
    prev_d  <= lat_d;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready && n < 30) begin
      step();
      n++;
    end
    ok = req_ready;
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_init();
    for (int c = 1; c <= P + 1; c++) begin
      chk("init_clr", 32'(lat_clr), 32'(c <= P));
      chk("init_done", 32'(done), 32'(c == P + 1));
      chk("init_err", 32'(err), 32'(0));
      chk("init_ready", 32'(req_ready), 32'(0));
      chk("init_ctl", 32'({lat_en, lat_pre}), 32'(0));
      if (c <= P) step();
    end
    step();
    chk("init_ready_after", 32'(req_ready), 32'(1));
    chk("init_errcnt", 32'(err_cnt), 32'(0));
    bank_m = '0;
    last_d = '0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] data, input bit keep,
                       input bit fen, input logic [W-1:0] fval);
    int L;
    bit ok;
    bit errexp;
    logic [W-1:0] newbank;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    force_en  = fen;
    force_val = fval;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      force_en  = 1'b0;
      return;
    end
    step();
    if (!keep) req_valid = 1'b0;
    case (op)
      2'd0: begin L = 3 + H; newbank = data; end
      2'd1: begin L = P + 1; newbank = '1; end
      2'd2: begin L = P + 1; newbank = '0; end
      default: begin L = 1; newbank = bank_m; end
    endcase
    errexp = (op != 2'd3) && ((fen ? fval : newbank) != newbank);
    if (errexp && cnt_model < 255) cnt_model++;
    for (int c = 1; c <= L; c++) begin
      chk("en", 32'(lat_en), 32'(op == 2'd0 && c == 2));
      chk("pre", 32'(lat_pre), 32'(op == 2'd1 && c <= P));
      chk("clr", 32'(lat_clr), 32'(op == 2'd2 && c <= P));
      chk("done", 32'(done), 32'(c == L));
      chk("err", 32'(err), 32'(c == L && errexp));
      chk("ready_busy", 32'(req_ready), 32'(0));
      chk("lat_d", 32'(lat_d), 32'(op == 2'd0 ? data : last_d));
      if (c == L) begin
        chk("err_cnt", 32'(err_cnt), 32'(cnt_model));
        chk("bank", 32'(lq), 32'(newbank));
      end else begin
        step();
      end
    end
    step();
    force_en = 1'b0;
    chk("ready_idle", 32'(req_ready), 32'(1));
    chk("done_low", 32'(done), 32'(0));
    bank_m = newbank;
    if (op == 2'd0) last_d = data;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_clr", 32'(lat_clr), 32'(1));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_ctl", 32'({lat_en, lat_pre, done, err}), 32'(0));
    chk("rst_d", 32'(lat_d), 32'(0));
    rst_n = 1'b1;
    check_init();

    do_op(2'd0, 4'hA, 1'b0, 1'b0, '0);
    do_op(2'd1, 4'h0, 1'b1, 1'b0, '0);
    do_op(2'd2, 4'h0, 1'b0, 1'b0, '0);
    chk("final_q", 32'(lq), 32'(0));

    repeat (300) do_op(2'd0, 4'h5, 1'b0, 1'b1, 4'h4);
    chk("err_cnt_sat", 32'(err_cnt), 32'(255));

    do_op(2'd3, 4'h0, 1'b0, 1'b1, ~bank_m);

    // reset while the latches are open
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_data  = 4'h3;
    wait_ready(ok);
    step();
    req_valid = 1'b0;
    step();
    chk("mid_open_en", 32'(lat_en), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(lat_en), 32'(0));
    chk("mid_rst_clr", 32'(lat_clr), 32'(1));
    chk("mid_rst_cnt", 32'(err_cnt), 32'(0));
    repeat (2) begin
      step();
      chk("mid_rst_done", 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    cnt_model = 0;
    check_init();

    for (int i = 0; i < 150; i++) begin
      do_op(2'($urandom_range(0, 3)), W'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, W'($urandom));
    end
    req_valid = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
